fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end for the 6502 core; the producer side of the decoder's instruction_ready/instruction_done handshake.
- Reads the opcode byte at PC, then zero, one or two operand bytes, and assembles the operand address/immediate.
- Presents opcode plus address with instruction_ready, holds them until the decoder returns instruction_done, then fetches the next instruction.
- Sits between program memory and the decoder; owns the program counter.

Parameters:
- REG_WIDTH, 8, data/opcode width
- ADDR_WIDTH, 16, address/PC width
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- mem_addr  out  ADDR_WIDTH  program memory read address
- mem_rd  out  1  read strobe; data valid on mem_rdata the following cycle
- mem_rdata  in  REG_WIDTH  read data
- instruction_out  out  REG_WIDTH  opcode to decoder
- addr_out  out  ADDR_WIDTH  assembled operand (address or zero-extended immediate)
- instruction_ready  out  1  opcode/addr_out valid
- instruction_done  in  1  decoder finished current instruction
- pc_load  in  1  redirect PC (jump/branch)
- pc_load_val  in  ADDR_WIDTH  redirect target
- pc_out  out  ADDR_WIDTH  current PC
- illegal  out  1  see Optional Feature

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. During reset: state=OP_REQ, PC=RESET_PC, mem_rd=0, mem_addr=0, instruction_out=0, addr_out=0, instruction_ready=0, illegal=0.
- Reset mid-fetch or mid-present aborts immediately; partial operand bytes are discarded.
- States: OP_REQ, OP_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, PRESENT, HALT.
- *_REQ states: mem_addr=PC, mem_rd=1 for exactly one cycle, PC<=PC+1. PC wraps FFFF->0000.
- *_WAIT states: mem_rd=0; capture mem_rdata into opcode, lo or hi respectively.
- Operand length from the captured opcode (cc=op[1:0], bbb=op[4:2]):
  - bbb in {011,110,111}: 2 bytes.
  - bbb=010 with cc=10: 0 bytes.
  - Otherwise: 1 byte.
- Transitions:
  - OP_WAIT -> LO_REQ if length>=1, else PRESENT.
  - LO_WAIT -> HI_REQ if length=2, else PRESENT.
  - HI_WAIT -> PRESENT.
- addr_out: length 0 -> 0; length 1 -> {8'h00, lo}; length 2 -> {hi, lo} (little-endian).
- Latency from OP_REQ entry to instruction_ready=1: 2 cycles (0-byte), 4 cycles (1-byte), 6 cycles (2-byte).
- PRESENT:
  - instruction_ready=1; instruction_out and addr_out stable.
  - Stay in PRESENT until instruction_done is sampled high, then go to OP_REQ with instruction_ready=0 the next cycle.
  - instruction_ready is therefore low for at least 2 cycles between instructions, giving the decoder a clean rising edge each instruction.
- pc_load is honoured only in PRESENT: PC<=pc_load_val. If sampled together with instruction_done, the next opcode is fetched from pc_load_val. pc_load in any other state is ignored.
- instruction_done outside PRESENT is ignored.
- pc_out always reflects the PC register.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - An opcode with cc=11 goes OP_WAIT -> HALT instead of fetching operands.
  - HALT: illegal=1, instruction_ready=0, mem_rd=0; PC points past the opcode.
  - HALT is left only by reset.
- Undefined:
  - cc=11 opcodes follow the length table like any other opcode.
  - illegal is tied 0 and HALT is unreachable.

Test Plan:
- Reset with RESET_PC=16'h0200, memory[0200]=A9, [0201]=42 -> two reads at 0200/0201; instruction_ready high 4 cycles after reset release with instruction_out=A9, addr_out=0042; pc_out=0202.
- Memory at 0300: AD 34 12, done pulsed 3 cycles after ready -> addr_out=1234, ready held until done, pc_out=0303, next opcode read at 0303.
- Memory at 0400: 0A -> 0-byte operand, ready 2 cycles after OP_REQ, addr_out=0000, pc_out=0401.
- PC=FFFE, memory[FFFE]=AD, [FFFF]=00, [0000]=80 -> hi byte read from 0000, addr_out=8000, pc_out=0001.
- In PRESENT, pc_load=1 with pc_load_val=0x1000 and instruction_done=1 -> next mem_addr=1000; pc_load pulsed during LO_WAIT -> no effect.
- Reset asserted during HI_WAIT -> instruction_ready never rises; refetch from RESET_PC. With FETCH_ILLEGAL_TRAP_EN, opcode 03 -> illegal=1, mem_rd stays 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, program memory and the decoder.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface fetch_unit_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic [REG_WIDTH-1:0]  instruction_out;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  instruction_ready;
    logic                  instruction_done;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_val;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  illegal;

    modport master (
        output mem_addr, mem_rd, instruction_out, addr_out,
               instruction_ready, pc_out, illegal,
        input  mem_rdata, instruction_done, pc_load, pc_load_val
    );

    modport slave (
        input  mem_addr, mem_rd, instruction_out, addr_out,
               instruction_ready, pc_out, illegal,
        output mem_rdata, instruction_done, pc_load, pc_load_val
    );
endinterface

// File: rtl/fetch_unit.sv
// 6502 instruction fetch front end: reads opcode plus 0-2 operand bytes and hands them to the decoder.
// Optional feature FETCH_ILLEGAL_TRAP_EN: cc=11 opcodes halt the unit with illegal=1 until reset.
module fetch_unit #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        OP_REQ  = 3'd0,
        OP_WAIT = 3'd1,
        LO_REQ  = 3'd2,
        LO_WAIT = 3'd3,
        HI_REQ  = 3'd4,
        HI_WAIT = 3'd5,
        PRESENT = 3'd6,
        HALT    = 3'd7
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [REG_WIDTH-1:0]  opcode_r;
    logic [1:0]            len_r;
    logic                  trap_s;
    logic                  req_s;

    // Operand byte count from the 6502 aaabbbcc opcode layout.
    function automatic logic [1:0] op_len(input logic [REG_WIDTH-1:0] op);
        logic [2:0] bbb;
        logic [1:0] cc;
        bbb = op[4:2];
        cc  = op[1:0];
        if ((bbb == 3'b011) || (bbb == 3'b110) || (bbb == 3'b111)) begin
            op_len = 2'd2;
        end else if ((bbb == 3'b010) && (cc == 2'b10)) begin
            op_len = 2'd0;
        end else begin
            op_len = 2'd1;
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= OP_REQ;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the opcode length is taken straight off mem_rdata in OP_WAIT.
    always_comb begin
        state_s = state_r;
`ifdef FETCH_ILLEGAL_TRAP_EN
        trap_s = (bus.mem_rdata[1:0] == 2'b11);
`else
        trap_s = 1'b0;
`endif
        case (state_r)
            OP_REQ:  state_s = OP_WAIT;
            OP_WAIT: begin
                if (trap_s) begin
                    state_s = HALT;
                end else if (op_len(bus.mem_rdata) == 2'd0) begin
                    state_s = PRESENT;
                end else begin
                    state_s = LO_REQ;
                end
            end
            LO_REQ:  state_s = LO_WAIT;
            LO_WAIT: begin
                if (len_r == 2'd2) begin
                    state_s = HI_REQ;
                end else begin
                    state_s = PRESENT;
                end
            end
            HI_REQ:  state_s = HI_WAIT;
            HI_WAIT: state_s = PRESENT;
            PRESENT: begin
                if (bus.instruction_done) begin
                    state_s = OP_REQ;
                end else begin
                    state_s = PRESENT;
                end
            end
            HALT:    state_s = HALT;
            default: state_s = OP_REQ;
        endcase
    end

    // Output decode; the read strobe is masked while reset is held so memory sees no request.
    always_comb begin
        req_s                 = (state_r == OP_REQ) || (state_r == LO_REQ) || (state_r == HI_REQ);
        bus.mem_rd            = req_s && reset_n;
        bus.mem_addr          = {ADDR_WIDTH{1'b0}};
        if (req_s && reset_n) begin
            bus.mem_addr = pc_r;
        end else begin
            bus.mem_addr = {ADDR_WIDTH{1'b0}};
        end
        bus.instruction_ready = (state_r == PRESENT);
        bus.instruction_out   = opcode_r;
        bus.addr_out          = addr_r;
        bus.pc_out            = pc_r;
`ifdef FETCH_ILLEGAL_TRAP_EN
        bus.illegal           = (state_r == HALT);
`else
        bus.illegal           = 1'b0;
`endif
    end

    // PC, opcode and operand assembly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r     <= RESET_PC;
            opcode_r <= {REG_WIDTH{1'b0}};
            addr_r   <= {ADDR_WIDTH{1'b0}};
            len_r    <= 2'd0;
        end else begin
            case (state_r)
                OP_REQ, LO_REQ, HI_REQ: pc_r <= pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                OP_WAIT: begin
                    opcode_r <= bus.mem_rdata;
                    len_r    <= op_len(bus.mem_rdata);
                    addr_r   <= {ADDR_WIDTH{1'b0}};
                end
                LO_WAIT: addr_r <= {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, bus.mem_rdata};
                HI_WAIT: addr_r[2*REG_WIDTH-1:REG_WIDTH] <= bus.mem_rdata;
                PRESENT: begin
                    if (bus.pc_load) begin
                        pc_r <= bus.pc_load_val;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: pc_r <= pc_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of redirect targets plus hand-written corner sequences.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus();

    fetch_unit #(.REG_WIDTH(8), .ADDR_WIDTH(16), .RESET_PC(16'h0200)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Program memory: one-cycle read latency, and a log of every address read.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_q.push_back(bus.mem_addr);
        end
    end

    typedef struct {
        logic [15:0] target;
        logic [7:0]  op;
        logic [15:0] addr;
        logic [15:0] pc;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while ((bus.instruction_ready !== 1'b1) && (cyc < 40)) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready expected ready within 40 cycles");
        end
    endtask

    // Called in PRESENT at a negedge; returns at the negedge of the new OP_REQ cycle.
    task automatic redirect(input logic [15:0] t);
        rd_q.delete();
        bus.pc_load          = 1'b1;
        bus.pc_load_val      = t;
        bus.instruction_done = 1'b1;
        @(negedge clk);
        bus.pc_load          = 1'b0;
        bus.instruction_done = 1'b0;
    endtask

    initial begin
        int  cyc;
        logic seen_ready;

        reset_n              = 1'b0;
        bus.instruction_done = 1'b0;
        bus.pc_load          = 1'b0;
        bus.pc_load_val      = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        mem[16'h0300] = 8'hAD; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
        mem[16'h0303] = 8'hA9; mem[16'h0304] = 8'h55;
        mem[16'h0400] = 8'h0A;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        mem[16'h0500] = 8'hA2; mem[16'h0501] = 8'h7F;
        mem[16'h0600] = 8'h6C; mem[16'h0601] = 8'hFF; mem[16'h0602] = 8'h12;
        mem[16'h0700] = 8'h1D; mem[16'h0701] = 8'h00; mem[16'h0702] = 8'hC0;
        mem[16'h0800] = 8'h08; mem[16'h0801] = 8'h5A;
        mem[16'h1000] = 8'hAD; mem[16'h1001] = 8'hCD; mem[16'h1002] = 8'hAB;
        mem[16'h1003] = 8'hAD; mem[16'h1004] = 8'h11; mem[16'h1005] = 8'h22;
        mem[16'h2000] = 8'hA9; mem[16'h2001] = 8'h99;
        mem[16'h0900] = 8'h03; mem[16'h0901] = 8'h44;

        vecs[0] = '{16'h0400, 8'h0A, 16'h0000, 16'h0401, 2};
        vecs[1] = '{16'hFFFE, 8'hAD, 16'h8000, 16'h0001, 6};
        vecs[2] = '{16'h0500, 8'hA2, 16'h007F, 16'h0502, 4};
        vecs[3] = '{16'h0600, 8'h6C, 16'h12FF, 16'h0603, 6};
        vecs[4] = '{16'h0700, 8'h1D, 16'hC000, 16'h0703, 6};
        vecs[5] = '{16'h0800, 8'h08, 16'h005A, 16'h0802, 4};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", bus.instruction_ready, 1'b0);
        check("rst_mem_rd", bus.mem_rd, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 16'h0000);
        check("rst_instr", bus.instruction_out, 8'h00);
        check("rst_addr_out", bus.addr_out, 16'h0000);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_pc", bus.pc_out, 16'h0200);

        // First fetch from RESET_PC: LDA #$42
        rd_q.delete();
        reset_n = 1'b1;
        #1;
        check("t1_first_rd", bus.mem_rd, 1'b1);
        check("t1_first_addr", bus.mem_addr, 16'h0200);
        wait_ready(cyc);
        check("t1_latency", cyc, 4);
        check("t1_instr", bus.instruction_out, 8'hA9);
        check("t1_addr_out", bus.addr_out, 16'h0042);
        check("t1_pc", bus.pc_out, 16'h0202);
        check("t1_nreads", rd_q.size(), 2);
        check("t1_rd1", rd_q[1], 16'h0201);

        // Absolute operand, decoder holds off 3 cycles
        redirect(16'h0300);
        check("t2_req_addr", bus.mem_addr, 16'h0300);
        wait_ready(cyc);
        check("t2_latency", cyc, 6);
        check("t2_pc", bus.pc_out, 16'h0303);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_ready", bus.instruction_ready, 1'b1);
            check("t2_hold_addr", bus.addr_out, 16'h1234);
            check("t2_hold_instr", bus.instruction_out, 8'hAD);
        end
        bus.instruction_done = 1'b1;
        @(negedge clk);
        bus.instruction_done = 1'b0;
        check("t2_ready_drop", bus.instruction_ready, 1'b0);
        check("t2_next_rd", bus.mem_rd, 1'b1);
        check("t2_next_addr", bus.mem_addr, 16'h0303);
        @(negedge clk);
        check("t2_ready_low2", bus.instruction_ready, 1'b0);
        wait_ready(cyc);
        check("t2_next_instr", bus.instruction_out, 8'hA9);
        check("t2_next_oper", bus.addr_out, 16'h0055);

        // Table of redirect targets covering each operand length and PC wrap
        for (int v = 0; v < 6; v++) begin
            redirect(vecs[v].target);
            wait_ready(cyc);
            check("vec_latency", cyc, vecs[v].lat);
            check("vec_instr", bus.instruction_out, vecs[v].op);
            check("vec_addr_out", bus.addr_out, vecs[v].addr);
            check("vec_pc", bus.pc_out, vecs[v].pc);
            check("vec_first_rd", rd_q[0], vecs[v].target);
            check("vec_nreads", rd_q.size(), vecs[v].lat / 2);
        end

        // pc_load in LO_WAIT must be ignored
        redirect(16'h1000);
        check("t5_req_addr", bus.mem_addr, 16'h1000);
        @(negedge clk);
        @(negedge clk);
        check("t5_lo_addr", bus.mem_addr, 16'h1001);
        @(negedge clk);
        bus.pc_load          = 1'b1;
        bus.pc_load_val      = 16'h2000;
        bus.instruction_done = 1'b1;
        @(negedge clk);
        bus.pc_load          = 1'b0;
        bus.instruction_done = 1'b0;
        check("t5_hi_addr", bus.mem_addr, 16'h1002);
        wait_ready(cyc);
        check("t5_instr", bus.instruction_out, 8'hAD);
        check("t5_addr_out", bus.addr_out, 16'hABCD);
        check("t5_pc", bus.pc_out, 16'h1003);
        check("t5_nreads", rd_q.size(), 3);

        // Reset asserted during HI_WAIT aborts the fetch
        bus.instruction_done = 1'b1;
        @(negedge clk);
        bus.instruction_done = 1'b0;
        check("t6_op_addr", bus.mem_addr, 16'h1003);
        repeat (4) @(negedge clk);
        check("t6_hi_addr", bus.mem_addr, 16'h1005);
        @(negedge clk);
        reset_n    = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.instruction_ready) seen_ready = 1'b1;
        end
        check("t6_no_ready", seen_ready, 1'b0);
        check("t6_rst_rd", bus.mem_rd, 1'b0);
        check("t6_rst_addr_out", bus.addr_out, 16'h0000);
        check("t6_rst_pc", bus.pc_out, 16'h0200);
        rd_q.delete();
        reset_n = 1'b1;
        wait_ready(cyc);
        check("t6_refetch_rd", rd_q[0], 16'h0200);
        check("t6_refetch_instr", bus.instruction_out, 8'hA9);
        check("t6_refetch_lat", cyc, 4);

        // Opcode with cc=11
        redirect(16'h0900);
`ifdef FETCH_ILLEGAL_TRAP_EN
        repeat (2) @(negedge clk);
        check("t7_illegal", bus.illegal, 1'b1);
        check("t7_ready", bus.instruction_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t7_halt_rd", bus.mem_rd, 1'b0);
        end
        check("t7_pc", bus.pc_out, 16'h0901);
        check("t7_illegal_hold", bus.illegal, 1'b1);
`else
        wait_ready(cyc);
        check("t7_latency", cyc, 4);
        check("t7_addr_out", bus.addr_out, 16'h0044);
        check("t7_illegal", bus.illegal, 1'b0);
        check("t7_pc", bus.pc_out, 16'h0902);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
